// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional build macro UART_TX_ARB_HDR_EN prefixes every grant with a {4'hA, index} header byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BYTES = 0
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [NUM_REQ-1:0]     REQ_VALID_I,
    input  logic [8*NUM_REQ-1:0]   REQ_DATA_I,
    input  logic [NUM_REQ-1:0]     REQ_LAST_I,
    output logic [NUM_REQ-1:0]     REQ_READY_O,
    output logic                   TX_START_O,
    output logic [7:0]             TX_DATA_O,
    input  logic                   TX_DONE_I,
    output logic [NUM_REQ-1:0]     GRANT_O,
    output logic                   BUSY_O
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BYTES > 0) ? $clog2(MAX_BYTES + 1) : 1;

`ifdef UART_TX_ARB_HDR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_NEXT, ST_HDR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_NEXT} state_t;
`endif

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_found;
    logic             lo_found;
    logic             sel_found;
    logic [CNT_W-1:0] byte_cnt;
    logic             last_q;
    logic             budget_hit;
`ifdef UART_TX_ARB_HDR_EN
    logic             hdr_q;
`endif

    // Rotating priority: lowest valid index at or above rr_ptr wins, else lowest valid below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (REQ_VALID_I[i]) begin
                if (IDX_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
        end
        sel_found = hi_found | lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign budget_hit  = (MAX_BYTES != 0) && (byte_cnt == CNT_W'(MAX_BYTES));
    assign REQ_READY_O = (state == ST_SEND) ? GRANT_O : '0;
    assign BUSY_O      = (state != ST_IDLE);

    // TX_DATA_O and TX_START_O are loaded on the edge entering ST_SEND so the byte is already
    // registered while the start pulse is high; a requester holds its byte until READY anyway.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            GRANT_O    <= '0;
            TX_START_O <= 1'b0;
            TX_DATA_O  <= '0;
            byte_cnt   <= '0;
            last_q     <= 1'b0;
`ifdef UART_TX_ARB_HDR_EN
            hdr_q      <= 1'b0;
`endif
        end else begin
            TX_START_O <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant_idx  <= sel_idx;
                        GRANT_O    <= NUM_REQ'(1) << sel_idx;
                        TX_START_O <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
                        TX_DATA_O  <= {4'hA, 4'(sel_idx)};
                        state      <= ST_HDR;
`else
                        TX_DATA_O  <= REQ_DATA_I[{sel_idx, 3'b000} +: 8];
                        state      <= ST_SEND;
`endif
                    end
                end
                ST_SEND: begin
                    last_q   <= REQ_LAST_I[grant_idx];
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    state    <= ST_WAIT;
                end
`ifdef UART_TX_ARB_HDR_EN
                ST_HDR: begin
                    hdr_q <= 1'b1;
                    state <= ST_WAIT;
                end
`endif
                ST_WAIT: begin
                    if (TX_DONE_I) begin
`ifdef UART_TX_ARB_HDR_EN
                        if (hdr_q) begin
                            hdr_q <= 1'b0;
                            state <= ST_NEXT;
                        end else
`endif
                        if (last_q || budget_hit) begin
                            rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                            GRANT_O  <= '0;
                            byte_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (REQ_VALID_I[grant_idx]) begin
                        TX_START_O <= 1'b1;
                        TX_DATA_O  <= REQ_DATA_I[{grant_idx, 3'b000} +: 8];
                        state      <= ST_SEND;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
